// File: rtl/audio_port_slave.sv
//------------------------------------------------------------------------------
// Module : audio_port_slave
// Brief  : Two-slot serial audio port slave driven by external BCLK/LRCK.
// Rev    : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module audio_port_slave (
  input  logic        clk,
  input  logic        rst,
  input  logic        bclk_in,
  input  logic        lrck_in,
  input  logic        sdi,
  output logic        sdo,
  output logic [23:0] rx_left,
  output logic [23:0] rx_right,
  output logic        rx_valid,
  input  logic [23:0] tx_left,
  input  logic [23:0] tx_right,
  output logic        tx_load,
  output logic        sync_err
);

  localparam logic [5:0] SLOT_BITS = 6'd32;
  localparam logic [5:0] CNT_MAX   = 6'd63;

  // {bclk, lrck, sdi} synchronizer stages, then edge-detect register for clocks
  logic [2:0]  sync1;
  logic [2:0]  sync2;
  logic [1:0]  dly;
  logic [1:0]  prime;
  logic        seen;
  logic [5:0]  bit_cnt;
  logic [23:0] rx_sr;
  logic [30:0] tx_sr;
  logic [23:0] tx_hold;

  logic primed;
  logic bclk_rise;
  logic bclk_fall;
  logic lrck_edge;
  logic closing_high;

  // Edges are masked until the pipeline has refilled after reset, so a pin
  // sitting high at release is not mistaken for a transition.
  assign primed       = (prime == 2'd3);
  assign bclk_rise    = primed &  sync2[2] & ~dly[1];
  assign bclk_fall    = primed & ~sync2[2] &  dly[1];
  assign lrck_edge    = primed & (sync2[1] ^ dly[0]);
  assign closing_high = dly[0];

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1 <= '0;
      sync2 <= '0;
      dly   <= '0;
      prime <= '0;
    end else begin
      sync1 <= {bclk_in, lrck_in, sdi};
      sync2 <= sync1;
      dly   <= sync2[2:1];
      if (!primed) prime <= prime + 2'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      seen     <= 1'b0;
      bit_cnt  <= '0;
      rx_sr    <= '0;
      tx_sr    <= '0;
      tx_hold  <= '0;
      sdo      <= 1'b0;
      rx_left  <= '0;
      rx_right <= '0;
      rx_valid <= 1'b0;
      tx_load  <= 1'b0;
      sync_err <= 1'b0;
    end else begin
      rx_valid <= 1'b0;
      tx_load  <= 1'b0;
      sync_err <= 1'b0;
      if (lrck_edge) begin
        // Slot boundary: any coincident BCLK edge is deliberately dropped.
        bit_cnt <= '0;
        seen    <= 1'b1;
        if (seen) begin
          if (bit_cnt == SLOT_BITS) begin
            if (!closing_high) begin
              rx_left <= rx_sr;
            end else begin
              rx_right <= rx_sr;
              rx_valid <= 1'b1;
            end
          end else begin
            sync_err <= 1'b1;
          end
        end
        if (closing_high) begin
          tx_sr   <= {tx_left[22:0], 8'h00};
          sdo     <= tx_left[23];
          tx_hold <= tx_right;
          tx_load <= 1'b1;
        end else begin
          tx_sr <= {tx_hold[22:0], 8'h00};
          sdo   <= tx_hold[23];
        end
      end else begin
        // Only the last 24 received bits matter for right-justified data.
        if (bclk_rise) begin
          rx_sr <= {rx_sr[22:0], sync2[0]};
          if (bit_cnt != CNT_MAX) bit_cnt <= bit_cnt + 6'd1;
        end
        if (bclk_fall) begin
          tx_sr <= {tx_sr[29:0], 1'b0};
          sdo   <= tx_sr[30];
        end
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_audio_port_slave.sv
//------------------------------------------------------------------------------
// Module : tb_audio_port_slave
// Brief  : Directed bench for audio_port_slave with a simple BCLK/LRCK master.
// Rev    : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_audio_port_slave;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        bclk_in = 1'b1;
  logic        lrck_in = 1'b1;
  logic        sdi = 1'b0;
  logic        sdo;
  logic [23:0] rx_left;
  logic [23:0] rx_right;
  logic        rx_valid;
  logic [23:0] tx_left = '0;
  logic [23:0] tx_right = '0;
  logic        tx_load;
  logic        sync_err;

  int checks = 0;
  int errors = 0;
  int n_valid = 0;
  int n_err = 0;
  int n_load = 0;

  logic [31:0] got;
  logic        tail;

  audio_port_slave dut (
    .clk      (clk),
    .rst      (rst),
    .bclk_in  (bclk_in),
    .lrck_in  (lrck_in),
    .sdi      (sdi),
    .sdo      (sdo),
    .rx_left  (rx_left),
    .rx_right (rx_right),
    .rx_valid (rx_valid),
    .tx_left  (tx_left),
    .tx_right (tx_right),
    .tx_load  (tx_load),
    .sync_err (sync_err)
  );

  always #5 clk = ~clk;

  // Pulse counters: cycles high, so a stretched pulse shows up as an extra count.
  always @(posedge clk) begin
    if (rx_valid) n_valid++;
    if (sync_err) n_err++;
    if (tx_load)  n_load++;
  end

  task automatic wait_clk(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_outputs_zero(input string tag);
    chk({tag, "_sdo"},      {31'd0, sdo},      32'd0);
    chk({tag, "_rx_left"},  {8'd0, rx_left},   32'd0);
    chk({tag, "_rx_right"}, {8'd0, rx_right},  32'd0);
    chk({tag, "_rx_valid"}, {31'd0, rx_valid}, 32'd0);
    chk({tag, "_tx_load"},  {31'd0, tx_load},  32'd0);
    chk({tag, "_sync_err"}, {31'd0, sync_err}, 32'd0);
  endtask

  // One slot from the master: BCLK half period 3 clk, data right-justified.
  // coinc puts the LRCK change on an extra BCLK rising edge ahead of the slot.
  task automatic slot(input logic lr, input bit edge_start, input bit coinc,
                      input logic [23:0] word, input int nper,
                      output logic [31:0] g, output logic t);
    int b;
    g = '0;
    t = 1'b0;
    if (coinc) begin
      bclk_in = 1'b0;
      sdi     = 1'b0;
      wait_clk(3);
      bclk_in = 1'b1;
      lrck_in = lr;
      wait_clk(3);
    end
    for (int i = 0; i < nper; i++) begin
      b = nper - 1 - i;
      bclk_in = 1'b0;
      if (i == 0 && edge_start && !coinc) lrck_in = lr;
      sdi = (b < 24) ? word[b] : 1'b0;
      wait_clk(3);
      bclk_in = 1'b1;
      wait_clk(3);
      if (i < 32) g[31 - i] = sdo;
      else        t = sdo;
    end
  endtask

  initial begin
    tx_left  = 24'hC00001;
    tx_right = 24'h7FFFFF;
    wait_clk(4);
    chk_outputs_zero("reset");
    rst = 1'b0;
    wait_clk(6);

    // Clean frames and TX encoding
    slot(1'b0, 1'b1, 1'b0, 24'h123456, 32, got, tail);
    chk("L1_sdo", got, 32'hC0000100);
    tx_left = 24'h800000;
    slot(1'b1, 1'b1, 1'b0, 24'hABCDEF, 32, got, tail);
    chk("R1_sdo", got, 32'h7FFFFF00);
    chk("R1_rx_left", {8'd0, rx_left}, 32'h00123456);
    slot(1'b0, 1'b1, 1'b0, 24'h123456, 32, got, tail);
    chk("L2_sdo", got, 32'h80000000);
    chk("L2_rx_right", {8'd0, rx_right}, 32'h00ABCDEF);
    chk("L2_rx_left", {8'd0, rx_left}, 32'h00123456);
    chk("L2_n_valid", n_valid, 1);
    chk("L2_n_load", n_load, 2);
    tx_right = 24'h000001;
    slot(1'b1, 1'b1, 1'b0, 24'hABCDEF, 32, got, tail);
    chk("R2_sdo", got, 32'h7FFFFF00);
    tx_left = 24'hC00001;

    // Short right slot
    slot(1'b0, 1'b1, 1'b0, 24'h654321, 32, got, tail);
    chk("L3_n_valid", n_valid, 2);
    slot(1'b1, 1'b1, 1'b0, 24'h0F0F0F, 31, got, tail);
    slot(1'b0, 1'b1, 1'b0, 24'h222222, 32, got, tail);
    chk("short_n_err", n_err, 1);
    chk("short_n_valid", n_valid, 2);
    chk("short_rx_right", {8'd0, rx_right}, 32'h00ABCDEF);
    chk("short_rx_left", {8'd0, rx_left}, 32'h00654321);
    chk("L4_sdo", got, 32'hC0000100);
    slot(1'b1, 1'b1, 1'b0, 24'h333333, 32, got, tail);
    chk("R4_rx_left", {8'd0, rx_left}, 32'h00222222);

    // Long left slot
    slot(1'b0, 1'b1, 1'b0, 24'h444444, 33, got, tail);
    chk("recover_rx_right", {8'd0, rx_right}, 32'h00333333);
    chk("recover_n_valid", n_valid, 3);
    chk("L5_sdo", got, 32'hC0000100);
    chk("L5_sdo_tail", {31'd0, tail}, 32'd0);
    slot(1'b1, 1'b1, 1'b0, 24'h555555, 32, got, tail);
    chk("long_n_err", n_err, 2);
    chk("long_rx_left", {8'd0, rx_left}, 32'h00222222);

    // LRCK change coincident with a BCLK rising edge
    slot(1'b0, 1'b1, 1'b0, 24'h0ABCDE, 32, got, tail);
    chk("L6_rx_right", {8'd0, rx_right}, 32'h00555555);
    chk("L6_n_valid", n_valid, 4);
    slot(1'b1, 1'b1, 1'b1, 24'h13579B, 32, got, tail);
    chk("coinc_rx_left", {8'd0, rx_left}, 32'h000ABCDE);
    slot(1'b0, 1'b1, 1'b0, 24'hAAAAAA, 32, got, tail);
    chk("coinc_rx_right", {8'd0, rx_right}, 32'h0013579B);
    chk("coinc_n_err", n_err, 2);
    chk("coinc_n_valid", n_valid, 5);

    // Reset in the middle of a right slot
    slot(1'b1, 1'b1, 1'b0, 24'h999999, 15, got, tail);
    rst = 1'b1;
    wait_clk(1);
    chk_outputs_zero("midrst");
    wait_clk(2);
    rst = 1'b0;
    slot(1'b1, 1'b0, 1'b0, 24'h999999, 17, got, tail);
    slot(1'b0, 1'b1, 1'b0, 24'h777777, 32, got, tail);
    chk("postrst_n_err", n_err, 2);
    chk("postrst_rx_left0", {8'd0, rx_left}, 32'd0);
    slot(1'b1, 1'b1, 1'b0, 24'h888888, 32, got, tail);
    chk("postrst_rx_left", {8'd0, rx_left}, 32'h00777777);
    slot(1'b0, 1'b1, 1'b0, 24'h000000, 32, got, tail);
    chk("postrst_rx_right", {8'd0, rx_right}, 32'h00888888);
    chk("postrst_n_valid", n_valid, 6);
    chk("final_n_err", n_err, 2);
    chk("final_n_load", n_load, 9);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
